oem_bisu_feeder: RTL and testbench

- Upstream feeder for the 32/16 odd-even merge / bidirectional insertion sort core.
- Accepts a serial element stream over a valid/ready handshake and packs one frame of N elements into N/P wide beats of P lanes.
- Drives the core's lane bus, enable, invert and valid controls, plus the one-hot walking per-stage reset sequence (stage 1..P) that the core expects around each frame.
- Replaces hand-sequenced stimulus with a reusable, synthesizable front end.

---
 rtl/oem_bisu_feeder.sv | 138 +++++++++++++
 tb/tb_oem_bisu_feeder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/oem_bisu_feeder.sv
// Serial-to-lane front end for the odd-even merge / insertion sort core.
// Define FEEDER_PAD_LAST_EN to let in_last end a short frame with all-ones padding.
module oem_bisu_feeder #(
  parameter int unsigned W = 6,
  parameter int unsigned N = 32,
  parameter int unsigned P = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_last,
  input  logic           inv_cfg,
  output logic [P*W-1:0] din_bus,
  output logic           en_o,
  output logic           inv_o,
  output logic           vin_o,
  output logic [P-1:0]   seq_rst,
  output logic           busy
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned SW = $clog2(P);
  localparam int unsigned NB = N / P;

  typedef enum logic {StFill, StIssue} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [SW-1:0]    step_q, step_d;
  logic [SW-1:0]    beat_sel;
  logic [N*W-1:0]   frame_q, frame_d;
  logic             ready_q, ready_d;
  logic [P*W-1:0]   din_q, din_d;
  logic             en_q, inv_q, inv_d, vin_q, vin_d, busy_q, busy_d;
  logic [P-1:0]     seq_q, seq_d;
  logic             accept, last_elem, pad_en;

  assign accept    = in_valid && ready_q && (state_q == StFill);
  assign last_elem = (fill_q == CW'(N - 1));
  assign beat_sel  = step_q - SW'(1);

`ifdef FEEDER_PAD_LAST_EN
  assign pad_en = accept && in_last && !last_elem;
`else
  logic unused_last;
  assign unused_last = in_last;
  assign pad_en      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    step_d  = step_q;
    frame_d = frame_q;
    ready_d = ready_q;
    din_d   = '0;
    inv_d   = inv_q;
    vin_d   = 1'b0;
    seq_d   = '0;
    busy_d  = 1'b0;
    unique case (state_q)
      StFill: begin
        ready_d = 1'b1;
        if (accept) begin
          frame_d[32'(fill_q)*W +: W] = in_data;
          if (fill_q == '0) inv_d = inv_cfg;
          if (last_elem || pad_en) begin
            // Only a short frame leaves slots above the current one to pad.
            for (int unsigned j = 0; j < N; j++) begin
              if (pad_en && (j > 32'(fill_q))) frame_d[j*W +: W] = '1;
            end
            state_d = StIssue;
            ready_d = 1'b0;
            step_d  = '0;
            fill_d  = '0;
          end else begin
            fill_d = fill_q + CW'(1);
          end
        end
      end
      StIssue: begin
        seq_d  = {{(P-1){1'b0}}, 1'b1} << step_q;
        busy_d = 1'b1;
        // Step 0 only resets stage 1; beats follow one step behind the walking reset.
        if (step_q >= SW'(1) && step_q <= SW'(NB)) begin
          vin_d = 1'b1;
          din_d = frame_q[32'(beat_sel)*P*W +: P*W];
        end
        if (step_q == SW'(P - 1)) begin
          state_d = StFill;
          step_d  = '0;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      fill_q  <= '0;
      step_q  <= '0;
      frame_q <= '0;
      ready_q <= 1'b0;
      din_q   <= '0;
      en_q    <= 1'b0;
      inv_q   <= 1'b0;
      vin_q   <= 1'b0;
      seq_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      step_q  <= step_d;
      frame_q <= frame_d;
      ready_q <= ready_d;
      din_q   <= din_d;
      en_q    <= 1'b1;
      inv_q   <= inv_d;
      vin_q   <= vin_d;
      seq_q   <= seq_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready = ready_q;
  assign din_bus  = din_q;
  assign en_o     = en_q;
  assign inv_o    = inv_q;
  assign vin_o    = vin_q;
  assign seq_rst  = seq_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_oem_bisu_feeder.sv
// Directed bench for oem_bisu_feeder: full, stalled, short and aborted frames.
module tb_oem_bisu_feeder;
  localparam int unsigned W  = 6;
  localparam int unsigned N  = 32;
  localparam int unsigned P  = 16;
  localparam int unsigned NB = N / P;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_last = 1'b0;
  logic           inv_cfg = 1'b0;
  logic [P*W-1:0] din_bus;
  logic           en_o, inv_o, vin_o, busy;
  logic [P-1:0]   seq_rst;

  int n_total = 0;
  int n_bad   = 0;

  logic [W-1:0] fa [N];
  logic [W-1:0] fb [N];
  logic [W-1:0] tx [N];
  logic [W-1:0] ex [N];

  oem_bisu_feeder #(.W(W), .N(N), .P(P)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .inv_cfg  (inv_cfg),
    .din_bus  (din_bus),
    .en_o     (en_o),
    .inv_o    (inv_o),
    .vin_o    (vin_o),
    .seq_rst  (seq_rst),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check("wait_ready", in_ready, 1);
  endtask

  // Feed tx[0..count-1]; inv_cfg flips after element 0; optionally hold a junk request after.
  task automatic feed(input int count, input int gap, input bit inv0, input int last_at,
                      input bit hold);
    wait_ready();
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_data  = tx[i];
      inv_cfg  = (i == 0) ? inv0 : ~inv0;
      in_last  = (i == last_at);
      tick();
      if (i != count - 1 && gap > 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 6'h2a;
        repeat (gap) tick();
      end
    end
    in_last = 1'b0;
    if (hold) begin
      in_valid = 1'b1;
      in_data  = 6'd5;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic check_issue(input bit exp_inv);
    check("rdy_drop", in_ready, 0);
    check("seq_idle", seq_rst, 0);
    for (int s = 0; s < P; s++) begin
      logic [P*W-1:0] beat;
      beat = '0;
      tick();
      if (s >= 1 && s <= NB) begin
        for (int k = 0; k < P; k++) beat[k*W +: W] = ex[(s-1)*P + k];
      end
      check($sformatf("seq_rst s%0d", s), seq_rst, 128'(1) << s);
      check($sformatf("vin s%0d", s), vin_o, (s >= 1 && s <= NB));
      check($sformatf("din s%0d", s), din_bus, beat);
      check($sformatf("busy s%0d", s), busy, 1);
      check($sformatf("inv s%0d", s), inv_o, exp_inv);
      check($sformatf("rdy s%0d", s), in_ready, 0);
    end
    tick();
    check("rdy_back", in_ready, 1);
    check("seq_off", seq_rst, 0);
    check("busy_off", busy, 0);
    check("vin_off", vin_o, 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, " seq"}, seq_rst, 0);
    check({tag, " vin"}, vin_o, 0);
    check({tag, " en"}, en_o, 0);
    check({tag, " rdy"}, in_ready, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " din"}, din_bus, 0);
    check({tag, " inv"}, inv_o, 0);
    #3;
    rst_n = 1'b1;
    tick();
    check({tag, " en_up"}, en_o, 1);
    check({tag, " rdy_up"}, in_ready, 1);
  endtask

  initial begin
    fa = '{50, 43, 14, 37, 21, 25, 60, 7, 56, 30, 44, 49, 3, 39, 18, 63,
           7, 13, 19, 24, 10, 22, 29, 5, 12, 17, 27, 2, 15, 20, 9, 18};
    for (int i = 0; i < N; i++) fb[i] = W'((i * 7 + 3) % 64);

    // Reset values, then first edge after release.
    #2;
    check("rst rdy", in_ready, 0);
    check("rst en", en_o, 0);
    check("rst seq", seq_rst, 0);
    check("rst din", din_bus, 0);
    check("rst vin", vin_o, 0);
    check("rst busy", busy, 0);
    check("rst inv", inv_o, 0);
    #6;
    rst_n = 1'b1;
    tick();
    check("init en", en_o, 1);
    check("init rdy", in_ready, 1);

    // Back-to-back full frame; request held with data 5 throughout ISSUE.
    tx = fa; ex = fa;
    feed(N, 0, 1'b0, -1, 1'b1);
    check_issue(1'b0);

    // Backpressure plus direction latch; slot 0 must be 50, not the held 5.
    feed(N, 3, 1'b1, -1, 1'b0);
    check_issue(1'b1);

    // Next frame with inv_cfg=0 on element 0 clears the direction.
    tx = fb; ex = fb;
    feed(N, 0, 1'b0, -1, 1'b0);
    check_issue(1'b0);

`ifdef FEEDER_PAD_LAST_EN
    for (int i = 0; i < N; i++) begin
      tx[i] = W'(i + 1);
      ex[i] = (i < 20) ? W'(i + 1) : 6'd63;
    end
    feed(20, 0, 1'b0, 19, 1'b0);
    check_issue(1'b0);
`else
    // in_last is ignored: the frame still takes all N elements.
    tx = fb; ex = fb;
    feed(N, 0, 1'b0, 19, 1'b0);
    check_issue(1'b0);
`endif

    // Reset mid-FILL discards the partial frame.
    tx = fa;
    feed(5, 0, 1'b0, -1, 1'b0);
    pulse_reset("fill_rst");
    tx = fb; ex = fb;
    feed(N, 0, 1'b0, -1, 1'b0);
    check_issue(1'b0);

    // Reset at ISSUE step 5 aborts the walking sequence.
    tx = fa;
    feed(N, 0, 1'b1, -1, 1'b0);
    repeat (6) tick();
    check("pre_rst seq", seq_rst, 16'h0020);
    pulse_reset("issue_rst");
    tx = fa; ex = fa;
    feed(N, 0, 1'b0, -1, 1'b0);
    check_issue(1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
